// File: rtl/zorro_ac_sequencer_if.sv
// Purpose: CPU-side AutoConfig write bus seen by the chain sequencer.
// Latency: none, this is wiring only.
// Backpressure: none. The CPU bus is never stalled, and writes are sampled on clk7_en.
//
// Signals:
//   clk7_en    - 7 MHz qualifier. All config-write sampling is gated by it.
//   sel        - CPU access falls inside the AutoConfig window.
//   address_in - CPU address bits [8:1].
//   data_in    - CPU write data.
//   hwr/lwr    - high- and low-byte write strobes.
// Modports: master (CPU decode drives the bus), slave (sequencer samples it).
interface zorro_ac_sequencer_if;
  logic        clk7_en;
  logic        sel;
  logic [7:0]  address_in;
  logic [15:0] data_in;
  logic        hwr;
  logic        lwr;

  modport master (output clk7_en, sel, address_in, data_in, hwr, lwr);
  modport slave  (input  clk7_en, sel, address_in, data_in, hwr, lwr);
endinterface

// File: rtl/zorro_ac_sequencer.sv
// Purpose: walks the Zorro AutoConfig chain, offering one present board at a time and capturing its base address.
// Latency: an accepted write leads to the next offer (or the null board) within NUM_BOARDS+1 clk. autoconfig_done is registered and lags by 1 clk.
// Backpressure: none. Writes that are not accepted are dropped, and the current offer holds until one is accepted.
//
// Ports:
//   clk, reset       - system clock; synchronous active-high reset.
//   cpu              - zorro_ac_sequencer_if.slave, carrying clk7_en/sel/address_in/data_in/hwr/lwr.
//   board_present    - per-slot enable. It is only looked at while scanning.
//   ac_index         - slot currently offered; 3'b111 = null board.
//   ac_active        - a real board is being offered.
//   board_configured - sticky per-slot configured flags.
//   board_shutup     - sticky per-slot shut-up flags.
//   base_addr        - 16 bits per slot: ZII {8'h00,A23:16}, ZIII A31:16.
//   autoconfig_done  - chain exhausted and acknowledged by a CPU window access.
// Optional: defining AC_TIMEOUT_EN auto-shuts-up a board that is left unanswered for TIMEOUT clk7_en ticks.
module zorro_ac_sequencer #(
  parameter int                    NUM_BOARDS = 5,
  parameter logic [NUM_BOARDS-1:0] ZIII_MASK  = 5'b01110
`ifdef AC_TIMEOUT_EN
  ,
  parameter logic [15:0]           TIMEOUT    = 16'd50000
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  zorro_ac_sequencer_if.slave       cpu,
  input  logic [NUM_BOARDS-1:0]     board_present,
  output logic [2:0]                ac_index,
  output logic                      ac_active,
  output logic [NUM_BOARDS-1:0]     board_configured,
  output logic [NUM_BOARDS-1:0]     board_shutup,
  output logic [16*NUM_BOARDS-1:0]  base_addr,
  output logic                      autoconfig_done
);

  typedef enum logic [1:0] {ST_INIT, ST_SCAN, ST_OFFER, ST_DONE} state_t;

  localparam logic [2:0] LAST_SLOT  = 3'(NUM_BOARDS);
  localparam logic [2:0] NULL_BOARD = 3'b111;

  state_t                    state_q, state_nxt;
  logic [2:0]                ptr_q, ptr_nxt;
  logic [2:0]                idx_nxt;
  logic                      act_nxt;
  logic [NUM_BOARDS-1:0]     cfg_nxt, shut_nxt;
  logic [16*NUM_BOARDS-1:0]  base_nxt;
  logic                      done_nxt;
  logic                      leave_offer;

  logic       cpu_wr;
  logic [8:0] wr_addr;
  logic       is_z3;
  logic       cfg_hit;
  logic       shut_hit;

  // A write counts only when it is qualified by the 7 MHz enable and falls inside the window.
  assign cpu_wr  = cpu.clk7_en && cpu.sel && (cpu.hwr || cpu.lwr);
  assign wr_addr = {cpu.address_in, 1'b0};
  // ac_index is only meaningful in OFFER, so that is the only place is_z3 is consumed.
  assign is_z3   = ZIII_MASK[ac_index];
  // The base lives in the high byte, so an lwr-only write cannot configure.
  // The ZII alias at 0x48 is deliberately dead for ZIII boards.
  assign cfg_hit  = cpu_wr && cpu.hwr &&
                    ((is_z3 && wr_addr == 9'h044) || (!is_z3 && wr_addr == 9'h048));
  assign shut_hit = cpu_wr && (wr_addr == 9'h04c);

`ifdef AC_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_INIT;
      ptr_q            <= '0;
      ac_index         <= NULL_BOARD;
      ac_active        <= 1'b0;
      board_configured <= '0;
      board_shutup     <= '0;
      base_addr        <= '0;
      autoconfig_done  <= 1'b0;
`ifdef AC_TIMEOUT_EN
      cnt_q            <= '0;
`endif
    end else begin
      state_q          <= state_nxt;
      ptr_q            <= ptr_nxt;
      ac_index         <= idx_nxt;
      ac_active        <= act_nxt;
      board_configured <= cfg_nxt;
      board_shutup     <= shut_nxt;
      base_addr        <= base_nxt;
      autoconfig_done  <= done_nxt;
`ifdef AC_TIMEOUT_EN
      cnt_q            <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state_q;
    ptr_nxt     = ptr_q;
    idx_nxt     = ac_index;
    act_nxt     = ac_active;
    cfg_nxt     = board_configured;
    shut_nxt    = board_shutup;
    base_nxt    = base_addr;
    done_nxt    = autoconfig_done;
    leave_offer = 1'b0;
`ifdef AC_TIMEOUT_EN
    cnt_nxt     = cnt_q;
`endif
    case (state_q)
      // One idle cycle lets board_present settle after reset.
      ST_INIT: begin
        state_nxt = ST_SCAN;
        ptr_nxt   = '0;
      end
      ST_SCAN: begin
        if (ptr_q >= LAST_SLOT) begin
          idx_nxt   = NULL_BOARD;
          state_nxt = ST_DONE;
        end else if (board_present[ptr_q] && !board_configured[ptr_q] && !board_shutup[ptr_q]) begin
          idx_nxt   = ptr_q;
          act_nxt   = 1'b1;
          state_nxt = ST_OFFER;
`ifdef AC_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end else begin
          ptr_nxt = ptr_q + 3'd1;
        end
      end
      ST_OFFER: begin
        // Configure and shut-up decode to different addresses, so at most one of them can fire.
        // A flag set here also ends the offer, which is why a slot never ends up with both flags.
        if (cfg_hit) begin
          cfg_nxt[ac_index]               = 1'b1;
          base_nxt[int'(ac_index)*16 +: 16] = is_z3 ? cpu.data_in : {8'h00, cpu.data_in[15:8]};
          leave_offer                     = 1'b1;
        end else if (shut_hit) begin
          shut_nxt[ac_index] = 1'b1;
          leave_offer        = 1'b1;
        end
`ifdef AC_TIMEOUT_EN
        // A real config write on the expiry tick wins, which is why this sits in the else branch.
        else if (cpu.clk7_en) begin
          if (cnt_q == TIMEOUT - 16'd1) begin
            shut_nxt[ac_index] = 1'b1;
            leave_offer        = 1'b1;
          end else begin
            cnt_nxt = cnt_q + 16'd1;
          end
        end
`endif
        if (leave_offer) begin
          act_nxt   = 1'b0;
          ptr_nxt   = ac_index + 3'd1;
          state_nxt = ST_SCAN;
        end
      end
      ST_DONE: begin
        if (cpu.clk7_en && cpu.sel) done_nxt = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_zorro_ac_sequencer.sv
// Purpose: exercises the AutoConfig chain sequencer using directed steps and randomized write traffic.
// Latency: each bus cycle is followed by a fixed settle window that is longer than the worst-case rescan.
// Backpressure: none. The bench drives the bus freely and compares against a slot-level reference model.
`timescale 1ns/1ps
module tb_zorro_ac_sequencer;
  localparam int            NB    = 5;
  localparam logic [NB-1:0] ZMASK = 5'b01110;
  localparam int            TMO   = 4;
  localparam int            NULLB = 7;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NB-1:0]        board_present;
  logic [2:0]           ac_index;
  logic                 ac_active;
  logic [NB-1:0]        board_configured;
  logic [NB-1:0]        board_shutup;
  logic [16*NB-1:0]     base_addr;
  logic                 autoconfig_done;

  zorro_ac_sequencer_if bus ();

  zorro_ac_sequencer #(
    .NUM_BOARDS(NB),
    .ZIII_MASK (ZMASK)
`ifdef AC_TIMEOUT_EN
    ,
    .TIMEOUT   (16'(TMO))
`endif
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu             (bus),
    .board_present   (board_present),
    .ac_index        (ac_index),
    .ac_active       (ac_active),
    .board_configured(board_configured),
    .board_shutup    (board_shutup),
    .base_addr       (base_addr),
    .autoconfig_done (autoconfig_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: slot flags, bases, the slot currently offered and the last slot that was retired.
  logic [NB-1:0] m_cfg, m_shut;
  logic [15:0]   m_base [NB];
  int            m_last, m_offer, m_ticks;
  bit            m_done;

  function automatic int next_offer();
    for (int j = m_last + 1; j < NB; j++)
      if (board_present[j] && !m_cfg[j] && !m_shut[j]) return j;
    return NULLB;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [16*NB-1:0] eb;
    for (int i = 0; i < NB; i++) eb[i*16 +: 16] = m_base[i];
    chk({tag, "/idx"},    80'(ac_index),         80'(m_offer));
    chk({tag, "/active"}, 80'(ac_active),        80'(m_offer != NULLB));
    chk({tag, "/cfg"},    80'(board_configured), 80'(m_cfg));
    chk({tag, "/shut"},   80'(board_shutup),     80'(m_shut));
    chk({tag, "/base"},   80'(base_addr),        80'(eb));
    chk({tag, "/done"},   80'(autoconfig_done),  80'(m_done));
  endtask

  task automatic bus_idle();
    bus.clk7_en = 1'b0; bus.sel = 1'b0; bus.hwr = 1'b0; bus.lwr = 1'b0;
    bus.address_in = 8'h00; bus.data_in = 16'h0000;
  endtask

  task automatic settle();
    repeat (NB + 3) @(negedge clk);
  endtask

  // Advance the model for one bus cycle using the slot-level rules of the chain.
  task automatic model_cycle(input bit ce, input bit s, input logic [8:0] a,
                             input logic [15:0] d, input bit hw, input bit lw);
    bit acc, z3;
    acc = 1'b0;
    if (m_offer == NULLB) begin
      if (ce && s) m_done = 1'b1;
      return;
    end
    if (!ce) return;
    if (s && (hw || lw)) begin
      z3 = ZMASK[m_offer];
      if (hw && ((z3 && a == 9'h044) || (!z3 && a == 9'h048))) begin
        m_cfg[m_offer]  = 1'b1;
        m_base[m_offer] = z3 ? d : {8'h00, d[15:8]};
        acc = 1'b1;
      end else if (a == 9'h04c) begin
        m_shut[m_offer] = 1'b1;
        acc = 1'b1;
      end
    end
`ifdef AC_TIMEOUT_EN
    if (!acc) begin
      m_ticks++;
      if (m_ticks == TMO) begin
        m_shut[m_offer] = 1'b1;
        acc = 1'b1;
      end
    end
`endif
    if (acc) begin
      m_last  = m_offer;
      m_ticks = 0;
      m_offer = next_offer();
    end
  endtask

  // Runs one bus cycle, called just after a negedge. The model is updated, then the chain is given time to rescan.
  task automatic cycle(input bit ce, input bit s, input logic [8:0] a,
                       input logic [15:0] d, input bit hw, input bit lw);
    bus.clk7_en = ce; bus.sel = s; bus.address_in = a[8:1];
    bus.data_in = d;  bus.hwr = hw; bus.lwr = lw;
    model_cycle(ce, s, {a[8:1], 1'b0}, d, hw, lw);
    @(negedge clk);
    bus_idle();
    settle();
  endtask

  task automatic do_reset(input logic [NB-1:0] p, input string tag);
    reset = 1'b1;
    board_present = p;
    bus_idle();
    repeat (2) @(negedge clk);
    chk({tag, "/rst_idx"},    80'(ac_index),         80'(3'b111));
    chk({tag, "/rst_active"}, 80'(ac_active),        80'(0));
    chk({tag, "/rst_cfg"},    80'(board_configured), 80'(0));
    chk({tag, "/rst_shut"},   80'(board_shutup),     80'(0));
    chk({tag, "/rst_base"},   80'(base_addr),        80'(0));
    chk({tag, "/rst_done"},   80'(autoconfig_done),  80'(0));
    reset = 1'b0;
    m_cfg = '0; m_shut = '0; m_last = -1; m_done = 1'b0; m_ticks = 0;
    for (int i = 0; i < NB; i++) m_base[i] = 16'h0000;
    m_offer = next_offer();
    settle();
    check_all({tag, "/post_rst"});
  endtask

  initial begin
    reset = 1'b1;
    board_present = '0;
    bus_idle();

    // Step 1: a single ZII board is configured at 0x48, then a window access marks the chain done.
    do_reset(5'b00001, "t1");
    cycle(1, 1, 9'h048, 16'h2000, 1, 0);
    check_all("t1_cfg");
    chk("t1_base0", 80'(base_addr[15:0]), 80'(16'h0020));
    chk("t1_idx",   80'(ac_index),        80'(3'b111));
    cycle(1, 1, 9'h000, 16'h0000, 0, 0);
    check_all("t1_done");
    chk("t1_done_k", 80'(autoconfig_done), 80'(1));

    // Step 2: two ZIII boards. The 0x48 alias and an lwr-only 0x44 write must both be ignored.
    do_reset(5'b00110, "t2");
    chk("t2_idx1", 80'(ac_index), 80'(1));
    cycle(1, 1, 9'h044, 16'h4000, 1, 0);
    check_all("t2_b1");
    cycle(1, 1, 9'h048, 16'h5500, 1, 0);
    check_all("t2_alias");
    chk("t2_alias_idx", 80'(ac_index), 80'(2));
    cycle(1, 1, 9'h044, 16'h6600, 0, 1);
    check_all("t2_lwr");
    cycle(1, 1, 9'h044, 16'h4400, 1, 0);
    cycle(1, 1, 9'h010, 16'h0000, 0, 0);
    check_all("t2_end");
    chk("t2_cfg", 80'(board_configured), 80'(5'b00110));

    // Step 3: board 0 is shut up, then board 4 is configured through ZII space.
    do_reset(5'b10001, "t3");
    cycle(1, 1, 9'h04c, 16'hFFFF, 0, 1);
    check_all("t3_shut");
    chk("t3_idx4", 80'(ac_index), 80'(4));
    cycle(1, 1, 9'h048, 16'hE900, 1, 0);
    check_all("t3_cfg");
    chk("t3_base4", 80'(base_addr[79:64]), 80'(16'h00E9));

    // Step 4: an empty chain goes straight to the null board.
    do_reset(5'b00000, "t4");
    cycle(1, 1, 9'h020, 16'h0000, 0, 0);
    check_all("t4_done");

    // Step 5: a reset in the middle of an offer discards everything captured so far.
    do_reset(5'b00110, "t5");
    cycle(1, 1, 9'h044, 16'h1234, 1, 0);
    check_all("t5_b1");
    do_reset(5'b00110, "t5b");
    chk("t5_reoffer", 80'(ac_index), 80'(1));

    // Step 6: dropping board_present mid-offer does not withdraw the offer, and an unqualified write is dropped.
    do_reset(5'b00011, "t6");
    board_present = 5'b00010;
    repeat (3) @(negedge clk);
    check_all("t6_hold");
    cycle(1, 1, 9'h048, 16'hAB00, 1, 0);
    check_all("t6_b0");
    cycle(0, 1, 9'h044, 16'h7700, 1, 0);
    check_all("t6_noce");
    cycle(1, 1, 9'h04c, 16'h0000, 0, 1);
    check_all("t6_shut1");

`ifdef AC_TIMEOUT_EN
    // Step 7: boards left unanswered are shut up one after another.
    do_reset(5'b00011, "t7");
    repeat (TMO) cycle(1, 0, 9'h000, 16'h0000, 0, 0);
    check_all("t7_to0");
    chk("t7_shut0", 80'(board_shutup), 80'(5'b00001));
    repeat (TMO) cycle(1, 0, 9'h000, 16'h0000, 0, 0);
    check_all("t7_to1");
    chk("t7_shut1", 80'(board_shutup), 80'(5'b00011));
`endif

    // Randomized traffic checked against the model.
    for (int r = 0; r < 15; r++) begin
      do_reset(NB'($urandom), "rnd_rst");
      for (int k = 0; k < 8; k++) begin
        logic [8:0] a;
        case ($urandom_range(0, 4))
          0:       a = 9'h044;
          1:       a = 9'h048;
          2:       a = 9'h04c;
          3:       a = {8'($urandom_range(0, 255)), 1'b0};
          default: a = 9'h048;
        endcase
        if ($urandom_range(0, 3) == 0) board_present = NB'($urandom);
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, a,
              16'($urandom), 1'($urandom), 1'($urandom));
        check_all("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/zorro_ac_sequencer.md
Name: zorro_ac_sequencer

Overview:
- Sequences the Zorro AutoConfig chain across up to NUM_BOARDS expansion boards: fast RAM, ZIII RAM banks, Toccata and ETH.
- Presents exactly one board at a time to the config window as `ac_index`, and steps to the next present board on each configure or shut-up write.
- Captures each board's assigned base address and publishes per-board configured/shut-up status to the address decoders.
- Sits between the CPU config-space decode (`sel`) and the AutoConfig ROM / board address decoders.

Parameters:
- NUM_BOARDS, 5, number of chain slots (index 0 = highest priority); max 7.
- ZIII_MASK, 5'b01110, bit i set = board i is Zorro III (configures at 0x44); clear = Zorro II (0x48).
- TIMEOUT, 16'd50000, clk7_en ticks before an unanswered offer is auto-shut-up (only with AC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- clk7_en  in  1  7 MHz qualifier; all config-write sampling gated by it
- sel  in  1  CPU access in AutoConfig window
- address_in  in  8  CPU address [8:1]
- data_in  in  16  CPU write data
- hwr  in  1  high-byte write strobe
- lwr  in  1  low-byte write strobe
- board_present  in  NUM_BOARDS  per-board enable from config, sampled in SCAN
- ac_index  out  3  board currently offered; 3'b111 = null board
- ac_active  out  1  a real board is offered (state OFFER)
- board_configured  out  NUM_BOARDS  sticky configured flags
- board_shutup  out  NUM_BOARDS  sticky shut-up flags
- base_addr  out  16*NUM_BOARDS  captured base per board (ZII: {8'h00,A23:16}; ZIII: A31:16)
- autoconfig_done  out  1  chain exhausted

Behaviour:
- Reset values: state=INIT, ac_index=3'b111, ac_active=0, board_configured=0, board_shutup=0, base_addr=0, autoconfig_done=0, scan pointer=0. Reset mid-offer aborts immediately and loses all captured state.
- INIT: one cycle, then SCAN. Gives board_present one cycle to settle after reset.
- SCAN: examines slot `ptr` (one slot per clk, not clk7_en gated).
  - If board_present[ptr] and slot neither configured nor shut up: ac_index<=ptr, ac_active<=1, go to OFFER.
  - Otherwise ptr<=ptr+1.
  - When ptr reaches NUM_BOARDS: ac_index<=3'b111, go to DONE.
  - Worst case NUM_BOARDS+1 cycles.
- OFFER: a write is `clk7_en && sel && (hwr|lwr)`, decoded on {address_in,1'b0}. ZII/ZIII is selected by ZIII_MASK[ac_index].
  - ZII board, write to 0x48 with hwr: base_addr[i]<={8'h00,data_in[15:8]}, board_configured[i]<=1.
  - ZIII board, write to 0x44 with hwr: base_addr[i]<=data_in[15:0], board_configured[i]<=1.
  - Write to 0x48 on a ZIII board is ignored; it is a duplicate ZII-space alias.
  - Write to 0x4c (either strobe), any board: board_shutup[i]<=1, base unchanged.
  - On any of the three accepted writes: ac_active<=0, ptr<=ac_index+1, go to SCAN. The next board appears within NUM_BOARDS+1 clk.
  - All other addresses, and reads, are ignored; the offer holds.
  - lwr-only write to 0x48/0x44 is ignored; the base is not latched.
- DONE: autoconfig_done<=1 on the first clk7_en&&sel cycle in DONE (registered, one clk latency). It stays 1 until reset. All writes are ignored.
- A configure and a shut-up for the same slot cannot coexist; the first accepted write wins and the slot is never re-offered.
- board_present deasserting during OFFER does not withdraw the offer. It only affects SCAN.

Optional Feature:
- Macro: AC_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to OFFER and increments on clk7_en while in OFFER. On reaching TIMEOUT, set board_shutup[i], then proceed exactly as a 0x4c write (ptr<=i+1, SCAN). A config write on the same cycle as expiry takes priority, and the counter is discarded.
- Undefined: no counter; OFFER waits indefinitely.

Test Plan:
- Present=5'b00001, ZII write 0x48 hwr data 16'h2000 at clk7_en → base_addr[0]=16'h0020, configured=5'b00001, ac_index 0→7, done=1 on next sel cycle.
- Present=5'b00110: ac_index=1 after reset; write 0x44 data 16'h4000 → base[1]=16'h4000, ac_index=2; write 0x48 (ignored, ac_index stays 2), then 0x44 data 16'h4400 → configured=5'b00110, done.
- Present=5'b10001: write 0x4c to board 0 → shutup=5'b00001, ac_index=4; write 0x48 data 16'hE900 → base[4]=16'h00E9, configured=5'b10000.
- Present=0 → ac_index=7, ac_active=0 throughout; done=1 after first sel cycle.
- Reset asserted in OFFER of board 2 after board 1 configured → all flags/bases 0, ac_index=7, re-offer of board 1 after INIT/SCAN.
- AC_TIMEOUT_EN, TIMEOUT=4, present=5'b00011, no writes → after 4 clk7_en ticks shutup=5'b00001, ac_index=1; after 4 more shutup=5'b00011, done.
